// File: rtl/subckt_eval_sched.sv
// Round-robin scheduler sharing one subcircuit-under-test among NREQ requesters.
// Optional HOLD timeout: define SUBCKT_SCHED_TIMEOUT_EN.
module subckt_eval_sched #(
  parameter int NREQ = 4,
  parameter int VW   = 5,
  parameter int LAT  = 3
) (
  input  logic                    I1470,
  input  logic                    I1477,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*VW-1:0]      req_vec,
  output logic [NREQ-1:0]         req_ready,
  output logic [VW-1:0]           dut_vec,
  input  logic                    dut_resp,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    rsp_data,
  output logic                    busy,
  output logic                    err_timeout
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t        state, nstate;
  logic [IW-1:0] ptr, win, win_hi, win_lo;
  logic          found_hi, found_lo;
  logic [VW-1:0] win_vec;
  logic [3:0]    cnt;
  logic          accept, sample, done, tmo;
`ifdef SUBCKT_SCHED_TIMEOUT_EN
  logic [3:0]    tcnt;
`endif

  // Two-pass search: first valid at/after ptr, otherwise first valid from 0.
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (req_valid[k] && !found_lo) begin
        win_lo   = IW'(k);
        found_lo = 1'b1;
      end
      if (req_valid[k] && !found_hi && (k >= 32'(ptr))) begin
        win_hi   = IW'(k);
        found_hi = 1'b1;
      end
    end
    win = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    win_vec   = '0;
    req_ready = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (win == IW'(k)) win_vec = req_vec[k*VW +: VW];
      req_ready[k] = I1477 && (state == IDLE) && found_lo && (win == IW'(k));
    end
  end

  always_ff @(posedge I1470 or negedge I1477) begin
    if (!I1477) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    accept = 1'b0;
    sample = 1'b0;
    done   = 1'b0;
    tmo    = 1'b0;
    case (state)
      IDLE: if (found_lo) begin
        accept = 1'b1;
        nstate = WAIT;
      end
      WAIT: if (cnt == 4'd1) begin
        sample = 1'b1;
        nstate = HOLD;
      end
      HOLD: begin
        if (rsp_ready) begin
          done   = 1'b1;
          nstate = IDLE;
        end
`ifdef SUBCKT_SCHED_TIMEOUT_EN
        else if (tcnt == 4'hF) begin
          tmo    = 1'b1;
          nstate = IDLE;
        end
`endif
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge I1470 or negedge I1477) begin
    if (!I1477) begin
      ptr       <= '0;
      dut_vec   <= '0;
      rsp_id    <= '0;
      rsp_data  <= 1'b0;
      rsp_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        dut_vec <= win_vec;
        rsp_id  <= win;
        cnt     <= 4'(LAT);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (sample) begin
        rsp_data  <= dut_resp;
        rsp_valid <= 1'b1;
      end
      if (done || tmo) begin
        rsp_valid <= 1'b0;
        ptr       <= (rsp_id == IW'(NREQ-1)) ? '0 : rsp_id + 1'b1;
      end
    end
  end

`ifdef SUBCKT_SCHED_TIMEOUT_EN
  always_ff @(posedge I1470 or negedge I1477) begin
    if (!I1477) begin
      tcnt        <= '0;
      err_timeout <= 1'b0;
    end else begin
      tcnt        <= (state == HOLD && !rsp_ready) ? tcnt + 4'd1 : '0;
      err_timeout <= tmo;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_subckt_eval_sched.sv
// Directed bench for subckt_eval_sched with a response scoreboard (NREQ=4, VW=5, LAT=3).
module tb_subckt_eval_sched;
  localparam int NREQ = 4;
  localparam int VW   = 5;
  localparam int LAT  = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [NREQ*VW-1:0]  req_vec;
  logic [VW-1:0]       dut_vec;
  logic                resp_drv, rsp_valid, rsp_ready, rsp_data, busy, err_timeout;
  logic [1:0]          rsp_id;

  typedef struct packed {
    logic [1:0] id;
    logic       data;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  int          n, glast, gidx, first_k, pulses;
  logic [1:0]  ids[5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic        bits[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [4:0]  vecs[4] = '{5'h0A, 5'h13, 5'h1C, 5'h05};

  subckt_eval_sched #(.NREQ(NREQ), .VW(VW), .LAT(LAT)) dut (
    .I1470      (clk),
    .I1477      (rst_n),
    .req_valid  (req_valid),
    .req_vec    (req_vec),
    .req_ready  (req_ready),
    .dut_vec    (dut_vec),
    .dut_resp   (resp_drv),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dut_vec"},   32'(dut_vec),     32'(0));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid),   32'(0));
    chk({tag, "_rsp_id"},    32'(rsp_id),      32'(0));
    chk({tag, "_rsp_data"},  32'(rsp_data),    32'(0));
    chk({tag, "_busy"},      32'(busy),        32'(0));
    chk({tag, "_err_to"},    32'(err_timeout), 32'(0));
    chk({tag, "_req_ready"}, 32'(req_ready),   32'(0));
  endtask

  task automatic sb_check(input string tag);
    exp_t x;
    if (sbq.size() == 0) begin
      chk({tag, "_unexpected"}, 32'(rsp_valid), 32'(0));
    end else begin
      x = sbq.pop_front();
      chk({tag, "_id"},   32'(rsp_id),   32'(x.id));
      chk({tag, "_data"}, 32'(rsp_data), 32'(x.data));
    end
  endtask

  task automatic await_grant(input string tag, input logic [3:0] exp, input logic d);
    int unsigned k = 0;
    exp_t x;
    while (req_ready == '0 && k < 12) begin
      tick();
      settle();
      k++;
    end
    chk(tag, 32'(req_ready), 32'(exp));
    x.data = d;
    x.id   = '0;
    for (int i = 0; i < 4; i++) if (exp[i]) x.id = 2'(i);
    sbq.push_back(x);
  endtask

  task automatic await_rsp(input string tag);
    int unsigned k = 0;
    while (!(rsp_valid && rsp_ready) && k < 12) begin
      tick();
      settle();
      k++;
    end
    if (rsp_valid && rsp_ready) sb_check(tag);
    else chk({tag, "_expired"}, 32'(rsp_valid && rsp_ready), 32'(1));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_vec   = '0;
    resp_drv  = 1'b0;
    rsp_ready = 1'b0;
    tick();
    tick();
    settle();
    chk_zero("reset");
    tick();
    rst_n = 1'b1;

    // Single request, vector 0x15, response 1
    tick();
    req_vec   = {15'h0, 5'h15};
    req_valid = 4'b0001;
    resp_drv  = 1'b1;
    rsp_ready = 1'b1;
    settle();
    chk("single_busy_T", 32'(busy), 32'(0));
    await_grant("single_grant", 4'b0001, 1'b1);
    tick();
    req_valid = '0;
    settle();
    chk("single_vec", 32'(dut_vec), 32'(5'h15));
    chk("single_busy", 32'(busy), 32'(1));
    chk("single_nordy", 32'(req_ready), 32'(0));
    tick(); settle();
    chk("single_v_T2", 32'(rsp_valid), 32'(0));
    tick(); settle();
    chk("single_v_T3", 32'(rsp_valid), 32'(0));
    tick(); settle();
    chk("single_v_T4", 32'(rsp_valid), 32'(1));
    sb_check("single");
    tick(); settle();
    chk("single_idle", 32'(busy), 32'(0));
    chk("single_clear", 32'(rsp_valid), 32'(0));

    // All four requesting: order 0,1,2,3,0 every LAT+2 cycles
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_vec = {vecs[3], vecs[2], vecs[1], vecs[0]};
    glast = -100;
    gidx  = 0;
    for (int c = 0; c < 27; c++) begin
      tick();
      if (c == 0) begin
        req_valid = 4'hF;
        rsp_ready = 1'b1;
      end
      if (c == 21) req_valid = '0;
      if (gidx == 0) resp_drv = 1'b0;
      else resp_drv = (c - glast == 3) ? bits[gidx-1] : ~bits[gidx-1];
      settle();
      if (req_ready != '0) begin
        if (gidx < 5) begin
          chk("rr_order", 32'(req_ready), 32'(4'b0001 << ids[gidx]));
          chk("rr_cycle", 32'(c), 32'(gidx * 5));
          e.id   = ids[gidx];
          e.data = bits[gidx];
          sbq.push_back(e);
          glast = c;
          gidx++;
        end else begin
          chk("rr_extra", 32'(req_ready), 32'(0));
        end
      end
      if (gidx > 0 && c == glast + 1) chk("rr_vec", 32'(dut_vec), 32'(vecs[ids[gidx-1]]));
      if (rsp_valid && rsp_ready) sb_check("rr");
    end
    chk("rr_count", 32'(gidx), 32'(5));

    // HOLD with rsp_ready low for 7 cycles, completion on the 8th
    tick();
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    resp_drv  = 1'b1;
    settle();
    await_grant("hold_grant", 4'b0010, 1'b1);
    tick();
    req_valid = '0;
    settle();
    n = 0;
    while (!rsp_valid && n < 8) begin
      tick(); settle(); n++;
    end
    chk("hold_rise", 32'(rsp_valid), 32'(1));
    for (int k = 0; k < 7; k++) begin
      chk("hold_valid", 32'(rsp_valid), 32'(1));
      chk("hold_id",    32'(rsp_id),    32'(1));
      chk("hold_data",  32'(rsp_data),  32'(1));
      tick();
      resp_drv = ~resp_drv;
      settle();
    end
    rsp_ready = 1'b1;
    settle();
    await_rsp("hold_done");
    tick(); settle();
    chk("hold_clear", 32'(rsp_valid), 32'(0));
    chk("hold_idle",  32'(busy),      32'(0));

    // Reset during WAIT aborts; next grant restarts at requester 0
    tick();
    req_valid = 4'b0100;
    resp_drv  = 1'b1;
    settle();
    await_grant("abort_grant", 4'b0100, 1'b1);
    tick();
    req_valid = '0;
    settle();
    tick(); settle();
    chk("abort_wait", 32'(busy), 32'(1));
    rst_n = 1'b0;
    settle();
    chk_zero("abort");
    sbq.delete();
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick(); settle();
      if (rsp_valid || busy) n++;
    end
    chk("abort_silent", 32'(n), 32'(0));
    tick();
    req_valid = 4'b1101;
    settle();
    await_grant("abort_next", 4'b0001, 1'b1);
    tick();
    req_valid = '0;
    settle();
    await_rsp("abort_next_done");

    // Requester 2 withdraws in WAIT; with ptr=2 requester 3 wins over 1
    tick();
    req_valid = 4'b0010;
    settle();
    await_grant("skip_grant1", 4'b0010, 1'b1);
    tick();
    req_valid = 4'b0100;
    settle();
    chk("skip_nordy_wait", 32'(req_ready), 32'(0));
    tick();
    req_valid = '0;
    settle();
    tick();
    req_valid = 4'b1010;
    settle();
    chk("skip_nordy_wait2", 32'(req_ready), 32'(0));
    tick(); settle();
    chk("skip_nordy_hold", 32'(req_ready), 32'(0));
    await_rsp("skip_done1");
    tick(); settle();
    await_grant("skip_grant3", 4'b1000, 1'b1);
    tick();
    req_valid = '0;
    settle();
    await_rsp("skip_done3");

    // rsp_ready held low in HOLD
    tick();
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    settle();
    await_grant("to_grant", 4'b0100, 1'b1);
    tick();
    req_valid = '0;
    settle();
    n = 0;
    while (!rsp_valid && n < 8) begin
      tick(); settle(); n++;
    end
    chk("to_rise", 32'(rsp_valid), 32'(1));
`ifdef SUBCKT_SCHED_TIMEOUT_EN
    pulses  = 0;
    first_k = -1;
    for (int k = 1; k <= 20; k++) begin
      tick(); settle();
      if (err_timeout) begin
        pulses++;
        if (first_k < 0) begin
          first_k = k;
          chk("to_drop", 32'(rsp_valid), 32'(0));
          chk("to_idle", 32'(busy),      32'(0));
        end
      end
    end
    chk("to_cycle",  32'(first_k), 32'(16));
    chk("to_pulses", 32'(pulses),  32'(1));
    sbq.delete();
`else
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      tick(); settle();
      if (!rsp_valid || err_timeout || !busy || rsp_id != 2'd2) n++;
    end
    chk("hold_forever", 32'(n), 32'(0));
    rsp_ready = 1'b1;
    settle();
    await_rsp("late_done");
    tick(); settle();
`endif
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    resp_drv  = 1'b0;
    settle();
    await_grant("post_ptr", 4'b1000, 1'b0);
    tick();
    req_valid = '0;
    settle();
    await_rsp("post_done");
    chk("sb_empty", 32'(sbq.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
